// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the memory/I-O access unit.
// Holds the FSM state encoding, default parameters and a helper that
// sizes the wait-state counter.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam int unsigned DEF_WAIT_STATES = 2;
  localparam logic [15:0] DEF_IO_ADDR     = 16'hFFFF;

  // Counter width: max(1, clog2(ws+1)) so that WAIT_STATES=0 still has a bit.
  function automatic int unsigned cnt_width(input int unsigned ws);
    int unsigned w;
    w = $clog2(ws + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response, SRAM and board-I/O bundle of the access unit.
// master: requester/environment side (drives request, SRAM read data, switches)
// slave : the access unit (drives ready, response, SRAM strobes, LEDs)
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LED_W  = 12
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_ce;
  logic              mem_we;
  logic              mem_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] sw_in;
  logic [LED_W-1:0]  led;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata, sw_in,
    input  req_ready, rsp_valid, rsp_rdata, mem_ce, mem_we, mem_oe,
           mem_addr, mem_wdata, led
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata, sw_in,
    output req_ready, rsp_valid, rsp_rdata, mem_ce, mem_we, mem_oe,
           mem_addr, mem_wdata, led
  );

endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter that times the SRAM wait states.
// Ports: clk, rst_n (async active-low), i_load/i_load_val (load),
//        i_dec (decrement, saturates at zero), o_zero (count is zero).
module wait_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Memory/I-O access controller: accepts one read or write per handshake,
// drives SRAM strobes for WAIT_STATES+1 cycles, and serves the
// memory-mapped I/O address internally (LED register / switch inputs).
// Ports: clk, reset (async active-low), bus_if (slave side of
//        mem_access_unit_if: request, response, SRAM and board I/O).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       WAIT_STATES = DEF_WAIT_STATES,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(DEF_IO_ADDR),
  parameter int unsigned       LED_W       = 12
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_unit_if.slave    bus_if
);

  localparam int unsigned CNT_W = cnt_width(WAIT_STATES);

  mem_state_t        r_state;
  mem_state_t        w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [LED_W-1:0]  r_led;

  logic w_accept;
  logic w_is_io;
  logic w_cnt_zero;
  logic w_req_ready;
  logic w_rsp_valid;
  logic w_mem_ce;
  logic w_mem_we;
  logic w_mem_oe;

  assign w_accept = (r_state == IDLE) && bus_if.req_valid;
  assign w_is_io  = (bus_if.req_addr == IO_ADDR);

  // Loaded on every SRAM accept, counts down through the ACCESS window.
  wait_counter #(.W(CNT_W)) u_wait_counter (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_accept && !w_is_io),
    .i_load_val (CNT_W'(WAIT_STATES)),
    .i_dec      (r_state == ACCESS),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus_if.req_valid) w_next = w_is_io ? DONE : ACCESS;
      ACCESS:  if (w_cnt_zero) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the registered state only, so strobes cannot glitch
  // and drop as soon as reset forces the state back to IDLE.
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_mem_ce    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_oe    = 1'b0;
    case (r_state)
      IDLE:    w_req_ready = 1'b1;
      ACCESS: begin
        w_mem_ce = 1'b1;
        w_mem_we = r_we;
        w_mem_oe = !r_we;
      end
      DONE:    w_rsp_valid = 1'b1;
      default: w_req_ready = 1'b0;
    endcase
  end

  // Request capture, I/O side effects and read-data return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_led   <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= bus_if.req_we;
        r_addr  <= bus_if.req_addr;
        r_wdata <= bus_if.req_wdata;
        if (w_is_io) begin
          if (bus_if.req_we) begin
            r_led <= bus_if.req_wdata[LED_W-1:0];
          end else begin
            r_rdata <= bus_if.sw_in;
          end
        end
      end
      // Last ACCESS cycle of a read: SRAM data has had the full window to settle.
      if ((r_state == ACCESS) && w_cnt_zero && !r_we) begin
        r_rdata <= bus_if.mem_rdata;
      end
    end
  end

  assign bus_if.req_ready = w_req_ready;
  assign bus_if.rsp_valid = w_rsp_valid;
  assign bus_if.rsp_rdata = r_rdata;
  assign bus_if.mem_ce    = w_mem_ce;
  assign bus_if.mem_we    = w_mem_we;
  assign bus_if.mem_oe    = w_mem_oe;
  assign bus_if.mem_addr  = r_addr;
  assign bus_if.mem_wdata = r_wdata;
  assign bus_if.led       = r_led;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a WAIT_STATES=2 instance under
// directed and random traffic, plus a WAIT_STATES=0 instance for
// back-to-back reads.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int unsigned WS  = 2;
  localparam logic [15:0] IOA = 16'hFFFF;

  typedef struct {
    bit          io;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    int          acc;
    int          done;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(16), .ADDR_W(16), .LED_W(12)) bus  ();
  mem_access_unit_if #(.DATA_W(16), .ADDR_W(16), .LED_W(12)) bus0 ();

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(WS), .IO_ADDR(IOA), .LED_W(12)) dut (
    .clk(clk), .reset(reset), .bus_if(bus));
  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(0), .IO_ADDR(IOA), .LED_W(12)) dut0 (
    .clk(clk), .reset(reset), .bus_if(bus0));

  // SRAM model (environment) and the bench's reference memory.
  logic [15:0] sram    [0:65535];
  logic [15:0] ref_mem [0:65535];
  assign bus.mem_rdata  = sram[bus.mem_addr];
  assign bus0.mem_rdata = sram[bus0.mem_addr];
  always @(posedge clk) if (bus.mem_ce && bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  txn_t        q[$];
  txn_t        q0[$];
  logic [11:0] m_led = '0;
  logic [15:0] m_rdata = '0;
  bit          mon_en = 1'b0;
  bit          sw_rand = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (sw_rand) bus.sw_in = 16'($urandom);

  // Monitor for the WAIT_STATES=2 instance.
  always @(negedge clk) begin : mon
    txn_t t;
    if (mon_en && reset) begin
      chk("req_ready", 32'(bus.req_ready), 32'(q.size() == 0));
      chk("led", 32'(bus.led), 32'(m_led));
      if (q.size() > 0) begin
        t = q[0];
        if (!t.io && cyc >= t.acc && cyc <= t.acc + int'(WS)) begin
          chk("strobes_access", 32'({bus.mem_ce, bus.mem_we, bus.mem_oe}), 32'({1'b1, t.we, !t.we}));
          chk("mem_addr", 32'(bus.mem_addr), 32'(t.addr));
          chk("mem_wdata", 32'(bus.mem_wdata), 32'(t.wdata));
        end else begin
          chk("strobes_off", 32'({bus.mem_ce, bus.mem_we, bus.mem_oe}), 32'(0));
        end
        if (bus.rsp_valid) begin
          chk("rsp_cycle", 32'(cyc), 32'(t.done));
          if (!t.we) m_rdata = t.exp;
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
          void'(q.pop_front());
        end else if (cyc >= t.done) begin
          chk("rsp_timeout", 32'(0), 32'(1));
          void'(q.pop_front());
        end
      end else begin
        chk("idle_outputs", 32'({bus.mem_ce, bus.mem_we, bus.mem_oe, bus.rsp_valid}), 32'(0));
      end
    end
  end

  // Monitor for the WAIT_STATES=0 instance.
  always @(negedge clk) begin : mon0
    txn_t t0;
    if (mon_en && reset && q0.size() > 0) begin
      t0 = q0[0];
      if (cyc == t0.acc)
        chk("ws0_strobes_on", 32'({bus0.mem_ce, bus0.mem_oe, bus0.mem_addr}), 32'({1'b1, 1'b1, t0.addr}));
      else
        chk("ws0_strobes_off", 32'(bus0.mem_ce), 32'(0));
      if (bus0.rsp_valid) begin
        chk("ws0_rsp_cycle", 32'(cyc), 32'(t0.done));
        chk("ws0_rsp_rdata", 32'(bus0.rsp_rdata), 32'(t0.exp));
        void'(q0.pop_front());
      end else if (cyc >= t0.done) begin
        chk("ws0_rsp_timeout", 32'(0), 32'(1));
        void'(q0.pop_front());
      end
    end
  end

  // Present a request, wait (bounded) for acceptance, push the expectation.
  task automatic do_req(input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    txn_t t;
    int   n;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 50);
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(0), 32'(1));
      return;
    end
    @(posedge clk);
    #1;
    t.io    = (addr == IOA);
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.acc   = cyc;
    t.done  = t.io ? cyc : cyc + int'(WS) + 1;
    t.exp   = '0;
    if (t.io && we)        m_led = wdata[11:0];
    else if (t.io)         t.exp = bus.sw_in;
    else if (we)           ref_mem[addr] = wdata;
    else                   t.exp = ref_mem[addr];
    q.push_back(t);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return IOA;
      1:       return 16'h3000;
      default: return 16'(16'h0040 + 16'($urandom_range(0, 7)));
    endcase
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    txn_t t;
    int   prev_acc;
    int   n;
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = init_val(16'(i));
      ref_mem[i] = init_val(16'(i));
    end
    sram[16'h3000]    = 16'hBEEF;
    ref_mem[16'h3000] = 16'hBEEF;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.sw_in = '0;
    #1 reset = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'({bus.req_ready, bus0.req_ready}), 32'(2'b11));
    chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'(0));
    chk("rst_strobes", 32'({bus.mem_ce, bus.mem_we, bus.mem_oe}), 32'(0));
    chk("rst_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 32'(0));
    chk("rst_led", 32'(bus.led), 32'(0));
    #2 reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // SRAM read, SRAM write with garbage after accept, IO write, IO read.
    do_req(1'b0, 16'h3000, 16'h1111);
    idle(6);
    do_req(1'b1, 16'h0040, 16'h1234);
    idle(6);
    do_req(1'b1, IOA, 16'hFABC);
    idle(3);
    sw_rand = 1'b0;
    bus.sw_in = 16'h00A5;
    do_req(1'b0, IOA, 16'h0000);
    idle(3);
    sw_rand = 1'b1;

    // Second request held during ACCESS must wait for IDLE.
    do_req(1'b0, 16'h0040, 16'h0000);
    do_req(1'b0, 16'h3000, 16'h0000);
    idle(7);

    // Reset in the middle of an ACCESS window.
    do_req(1'b1, IOA, 16'h0123);
    idle(2);
    do_req(1'b0, 16'h3000, 16'h0000);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_strobes", 32'({bus.mem_ce, bus.mem_we, bus.mem_oe}), 32'(0));
    chk("midrst_ready", 32'(bus.req_ready), 32'(1));
    chk("midrst_led_rsp", 32'({bus.led, bus.rsp_valid}), 32'(0));
    q.delete();
    m_led = '0;
    m_rdata = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      do_req(1'($urandom), rand_addr(), 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(10);
    chk("drain", 32'(q.size()), 32'(0));

    // WAIT_STATES=0 instance: back-to-back reads with req_valid held high.
    prev_acc = 0;
    bus0.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus0.req_addr = (i == 0) ? 16'h3000 : rand_addr();
      if (bus0.req_addr == IOA) bus0.req_addr = 16'h0041;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus0.req_ready && n < 20);
      if (!bus0.req_ready) begin
        chk("ws0_accept_timeout", 32'(0), 32'(1));
        break;
      end
      @(posedge clk); #1;
      t.io = 1'b0; t.we = 1'b0; t.addr = bus0.req_addr; t.wdata = '0;
      t.acc = cyc; t.done = cyc + 1; t.exp = ref_mem[bus0.req_addr];
      if (i > 0) chk("ws0_spacing", 32'(cyc - prev_acc), 32'(3));
      prev_acc = cyc;
      q0.push_back(t);
    end
    bus0.req_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("ws0_drain", 32'(q0.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory/I-O access controller for the SLC-3 datapath, replacing the fixed MAR/MDR/MEMIO path. It sits between the control FSM/datapath and the external SRAM. It accepts one read or write request per handshake and drives the SRAM strobes for a configurable number of wait states. Accesses to the memory-mapped I/O address are served internally: writes update the LED register, reads return the switch inputs.

## Interface
Parameters:
- DATA_W, 16, data width of bus, SRAM and switch input
- ADDR_W, 16, address width
- WAIT_STATES, 2, extra SRAM cycles per access; legal range 0–15
- IO_ADDR, 16'hFFFF, memory-mapped I/O address; full-width equality compare
- LED_W, 12, LED register width; write data bits [LED_W-1:0]

Ports (clk, reset first):
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  access address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse, reads and writes
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- mem_ce  out  1  SRAM chip enable, active-high
- mem_we  out  1  SRAM write enable, active-high
- mem_oe  out  1  SRAM output enable, active-high
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data
- sw_in  in  DATA_W  switch inputs, read at IO_ADDR
- led  out  LED_W  LED register

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE:**
  - req_ready=1.
  - On req_valid, capture req_we, req_addr and req_wdata.
  - If req_addr==IO_ADDR, go to DONE. Otherwise load the wait counter with WAIT_STATES and go to ACCESS.
- **IO accesses:**
  - Write: led <= req_wdata[LED_W-1:0] at the accept edge.
  - Read: rsp_rdata <= sw_in sampled at the accept edge.
  - No SRAM strobes are asserted.
- **ACCESS:**
  - mem_ce=1; mem_we=captured we; mem_oe=~captured we.
  - mem_addr and mem_wdata come from the captured registers.
  - The counter decrements each cycle. When the counter is 0, go to DONE; for reads, rsp_rdata <= mem_rdata on that edge.
- **DONE:** rsp_valid=1 for exactly one cycle, then return to IDLE.
- req_ready=0 in ACCESS and DONE. req_valid and the request fields are ignored while busy; changing them mid-access has no effect.
- Writes leave rsp_rdata unchanged.
- No backpressure on rsp_valid: the consumer must take it the cycle it appears.

## Timing
- **Reset values:**
  - State IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0.
  - mem_ce, mem_we and mem_oe = 0; mem_addr=0, mem_wdata=0.
  - led=0, counter=0.
- **Reset mid-access:** the FSM goes to IDLE asynchronously and the strobes drop immediately, without waiting for the clock edge. A pending rsp_valid is lost.
- **SRAM access**, accept at edge k:
  - ACCESS during cycles k+1 … k+1+WAIT_STATES, i.e. WAIT_STATES+1 strobe cycles.
  - rsp_valid during cycle k+WAIT_STATES+2.
  - req_ready=1 again at cycle k+WAIT_STATES+3.
- **IO access:** rsp_valid in cycle k+1; req_ready=1 in cycle k+2.
- **WAIT_STATES=0:** one ACCESS cycle; the counter width is max(1, $clog2(WAIT_STATES+1)).
- **Throughput:** back-to-back requests get one accept every WAIT_STATES+3 cycles (SRAM) or every 2 cycles (IO).
- **Strobe stability:** mem_addr and mem_wdata are stable across the whole ACCESS window; the strobes are glitch-free (registered state decode only).

## Structure
- Package mem_access_pkg holds:
  - enum typedef mem_state_t {IDLE, ACCESS, DONE};
  - defaults DEF_WAIT_STATES=2, DEF_IO_ADDR=16'hFFFF.
- Sub-module wait_counter (parameter W): load, decrement, zero flag, async active-low reset. Instantiated once.
- The capture registers, LED register and FSM live in mem_access_unit.

## Test plan
- **Reset:** hold reset=0 mid-ACCESS with WAIT_STATES=2.
  - Required: mem_ce/we/oe=0 immediately, led=0, req_ready=1.
  - After release: a fresh request completes normally.
- **SRAM read:** WAIT_STATES=2, read 16'h3000, mem_rdata=16'hBEEF.
  - Required: mem_ce=mem_oe=1 for 3 cycles.
  - Required: rsp_valid 4 cycles after the accept edge with rsp_rdata=16'hBEEF.
- **SRAM write:** 16'h1234 to 16'h0040, with req_addr/req_wdata changed to garbage the cycle after accept.
  - Required: mem_we=1, mem_addr=16'h0040, mem_wdata=16'h1234 held for all 3 cycles.
  - Required: rsp_rdata unchanged.
- **IO:**
  - Write 16'hFABC to 16'hFFFF: led=12'hABC next cycle, no SRAM strobes, rsp_valid at k+1.
  - Read with sw_in=16'h00A5: rsp_rdata=16'h00A5.
- **Busy ignore:** issue a second request during ACCESS.
  - Required: req_ready=0, not accepted; accepted only in the IDLE cycle after DONE.
- **WAIT_STATES=0, back-to-back reads** with req_valid held high.
  - Required: one-cycle ACCESS windows, rsp_valid every 3 cycles, correct data each time.
